// File: rtl/tmds_decoder.sv
// -----------------------------------------------------------------------------
// tmds_decoder
//   Per-channel 10b->8b TMDS/DVI decoder for the HDMI receive path. Decodes
//   video-data symbols, recognises the four control tokens, tracks running
//   disparity and runs a lock FSM that requests bit slips from the 1:10
//   deserializer until symbol alignment is found.
//
// Ports
//   clk_in         pixel clock
//   rst_in         asynchronous, active-low reset
//   tmds_in[9:0]   deserialized symbol, bit0 = first bit on the wire
//   tmds_valid_in  tmds_in valid this cycle
//   data_out[7:0]  decoded pixel byte
//   control_out    decoded control bits {c1,c0} (blue channel: {vsync,hsync})
//   ve_out         1 = data symbol, 0 = control token
//   valid_out      outputs valid; only asserted while locked
//   err_out        one-cycle pulse on a disparity error
//   locked_out     lock FSM is in LOCKED
//   bitslip_out    one-cycle pulse asking the deserializer to slip one bit
//   err_count_out  saturating disparity-error count
//
// Build option
//   TMDS_DEC_ERR_COUNT_EN  when defined, err_count_out is a 16-bit saturating
//                          error counter cleared only by reset; otherwise it
//                          is tied to zero.
// -----------------------------------------------------------------------------
module tmds_decoder #(
    parameter int LOCK_TOKENS    = 8,
    parameter int SEARCH_TIMEOUT = 2048,
    parameter int DISP_LIMIT     = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [9:0]  tmds_in,
    input  logic        tmds_valid_in,
    output logic [7:0]  data_out,
    output logic [1:0]  control_out,
    output logic        ve_out,
    output logic        valid_out,
    output logic        err_out,
    output logic        locked_out,
    output logic        bitslip_out,
    output logic [15:0] err_count_out
);
    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_SLIP   = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_LOCKED = 2'd3;

    localparam int TOK_W = $clog2(LOCK_TOKENS + 1);
    localparam int CNT_W = $clog2(SEARCH_TIMEOUT + 1);
    localparam logic [TOK_W-1:0]  TOK_MAX  = TOK_W'(LOCK_TOKENS);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(SEARCH_TIMEOUT);
    localparam logic signed [6:0] DISP_LIM = 7'(DISP_LIMIT);

    // Stage 1 registers
    logic [9:0] sym_reg;
    logic       sym_valid_reg;

    // Stage 2 / FSM registers
    logic [1:0]        state_reg,   state_next;
    logic [1:0]        wait_reg,    wait_next;
    logic [TOK_W-1:0]  tok_run_reg, tok_run_next;
    logic [CNT_W-1:0]  sym_cnt_reg, sym_cnt_next;
    logic signed [5:0] acc_reg,     acc_next;
    logic [7:0]        data_reg,    data_next;
    logic [1:0]        ctrl_reg,    ctrl_next;
    logic              ve_reg,      ve_next;
    logic              valid_reg,   valid_next;
    logic              err_reg,     err_next;
    logic              bitslip_reg, bitslip_next;

    // Symbol decode
    logic [7:0]        d_word;
    logic [7:0]        q_word;
    logic              is_token;
    logic [1:0]        tok_ctrl;
    logic [3:0]        ones;
    logic signed [6:0] sym_disp;
    logic signed [6:0] acc_sum;
    logic              data_err;
    logic [TOK_W-1:0]  tok_run_inc;
    logic [CNT_W-1:0]  sym_cnt_inc;
    logic              run_done;
    logic              timeout;

    assign d_word    = sym_reg[9] ? ~sym_reg[7:0] : sym_reg[7:0];
    assign q_word[0] = d_word[0];

    // bit 8 selects XOR vs XNOR chaining used by the encoder
    generate
        for (genvar gi = 1; gi < 8; gi++) begin : g_dec
            assign q_word[gi] = sym_reg[8] ? (d_word[gi] ^ d_word[gi-1])
                                           : ~(d_word[gi] ^ d_word[gi-1]);
        end
    endgenerate

    always_comb begin
        is_token = 1'b1;
        tok_ctrl = 2'b00;
        case (sym_reg)
            10'b1101010100: tok_ctrl = 2'b00;
            10'b0010101011: tok_ctrl = 2'b01;
            10'b0101010100: tok_ctrl = 2'b10;
            10'b1010101011: tok_ctrl = 2'b11;
            default:        is_token = 1'b0;
        endcase
    end

    always_comb begin
        ones = '0;
        for (int i = 0; i < 10; i++) begin
            ones = ones + {3'b000, sym_reg[i]};
        end
    end

    // ones - zeros = 2*ones - 10; before the add |acc| <= limit, so the sum
    // always fits the 7-bit intermediate
    assign sym_disp = $signed({2'b00, ones, 1'b0}) - 7'sd10;
    assign acc_sum  = $signed({acc_reg[5], acc_reg}) + sym_disp;
    assign data_err = !is_token && ((acc_sum > DISP_LIM) || (acc_sum < -DISP_LIM));

    assign tok_run_inc = (tok_run_reg == TOK_MAX) ? TOK_MAX : tok_run_reg + 1'b1;
    assign sym_cnt_inc = (sym_cnt_reg == CNT_MAX) ? CNT_MAX : sym_cnt_reg + 1'b1;
    assign run_done    = is_token && (tok_run_inc == TOK_MAX);
    assign timeout     = (sym_cnt_inc == CNT_MAX);

    always_comb begin
        state_next   = state_reg;
        wait_next    = wait_reg;
        tok_run_next = tok_run_reg;
        sym_cnt_next = sym_cnt_reg;
        acc_next     = acc_reg;
        data_next    = data_reg;
        ctrl_next    = ctrl_reg;
        ve_next      = ve_reg;
        valid_next   = 1'b0;
        err_next     = 1'b0;
        bitslip_next = 1'b0;
        case (state_reg)
            ST_SLIP: begin
                state_next   = ST_WAIT;
                wait_next    = '0;
                tok_run_next = '0;
                sym_cnt_next = '0;
            end
            ST_WAIT: begin
                // input ignored while the deserializer settles
                if (wait_reg == 2'd3) state_next = ST_SEARCH;
                else                  wait_next  = wait_reg + 2'd1;
            end
            default: begin
                if (sym_valid_reg) begin
                    valid_next = (state_reg == ST_LOCKED);
                    if (is_token) begin
                        ve_next      = 1'b0;
                        ctrl_next    = tok_ctrl;
                        acc_next     = '0;
                        tok_run_next = tok_run_inc;
                    end else begin
                        ve_next      = 1'b1;
                        data_next    = q_word;
                        tok_run_next = '0;
                        if (data_err) begin
                            acc_next = '0;
                            err_next = 1'b1;
                        end else begin
                            acc_next = acc_sum[5:0];
                        end
                    end
                    if (state_reg == ST_SEARCH) begin
                        // lock takes priority over a coincident timeout
                        if (run_done) begin
                            state_next   = ST_LOCKED;
                            sym_cnt_next = '0;
                        end else if (timeout) begin
                            state_next   = ST_SLIP;
                            bitslip_next = 1'b1;
                        end else begin
                            sym_cnt_next = sym_cnt_inc;
                        end
                    end else begin
                        if (data_err || (timeout && !run_done)) begin
                            state_next   = ST_SEARCH;
                            tok_run_next = '0;
                            sym_cnt_next = '0;
                        end else if (run_done) begin
                            sym_cnt_next = '0;
                        end else begin
                            sym_cnt_next = sym_cnt_inc;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sym_reg       <= '0;
            sym_valid_reg <= 1'b0;
            state_reg     <= ST_SEARCH;
            wait_reg      <= '0;
            tok_run_reg   <= '0;
            sym_cnt_reg   <= '0;
            acc_reg       <= '0;
            data_reg      <= '0;
            ctrl_reg      <= '0;
            ve_reg        <= 1'b0;
            valid_reg     <= 1'b0;
            err_reg       <= 1'b0;
            bitslip_reg   <= 1'b0;
        end else begin
            sym_reg       <= tmds_in;
            sym_valid_reg <= tmds_valid_in;
            state_reg     <= state_next;
            wait_reg      <= wait_next;
            tok_run_reg   <= tok_run_next;
            sym_cnt_reg   <= sym_cnt_next;
            acc_reg       <= acc_next;
            data_reg      <= data_next;
            ctrl_reg      <= ctrl_next;
            ve_reg        <= ve_next;
            valid_reg     <= valid_next;
            err_reg       <= err_next;
            bitslip_reg   <= bitslip_next;
        end
    end

`ifdef TMDS_DEC_ERR_COUNT_EN
    logic [15:0] err_cnt_reg;
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            err_cnt_reg <= '0;
        end else if (err_next && (err_cnt_reg != 16'hFFFF)) begin
            err_cnt_reg <= err_cnt_reg + 16'd1;
        end
    end
    assign err_count_out = err_cnt_reg;
`else
    assign err_count_out = 16'd0;
`endif

    assign data_out    = data_reg;
    assign control_out = ctrl_reg;
    assign ve_out      = ve_reg;
    assign valid_out   = valid_reg;
    assign err_out     = err_reg;
    assign locked_out  = (state_reg == ST_LOCKED);
    assign bitslip_out = bitslip_reg;

endmodule
